// File: rtl/ss_pkg.sv
// Shared types and constants for the four-digit scan controller.
package ss_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 3;
    localparam int FRAME_W = DIGITS * DIGIT_W;
    localparam int SEL_W   = $clog2(DIGITS);

    // Scan FSM state; plain constants keep the encoding legible in waveforms.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BLANK = 2'd1;
    localparam state_t ST_SHOW  = 2'd2;

    // Extract one digit from a packed frame (digit0 in the low bits).
    function automatic logic [DIGIT_W-1:0] digit_of(
        input logic [FRAME_W-1:0] frame,
        input logic [SEL_W-1:0]   idx
    );
        return frame[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/ss_phase_timer.sv
// Loadable down-counter that times one BLANK or SHOW phase.
// A phase of N clocks is timed by loading N-1; expired_o is high in the
// last clock of the phase, so the counter never wraps.
module ss_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == '0);

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (run_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ss_scan_ctrl.sv
// Multiplexed four-digit display scanner with a double-buffered frame:
// writes land in a pending buffer and are copied to the displayed shadow
// only at a frame boundary (or immediately while scanning is disabled).
module ss_scan_ctrl
    import ss_pkg::*;
#(
    parameter int SHOW_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               wr_valid,
    input  logic [FRAME_W-1:0] wr_data,
    output logic               wr_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [DIGIT_W-1:0] data,
    output logic               blank,
    output logic               frame_done
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(DIGITS - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [DIGIT_W-1:0]   data_q, data_d;
    logic                 blank_q, blank_d;
    logic                 fd_q, fd_d;
    logic                 wr_ready_q, wr_ready_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [FRAME_W-1:0]   pend_q, pend_d;
    logic                 arm_q;

    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic                 tmr_expired;
    logic                 accept;
    logic                 commit;

    ss_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (arm_q),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .expired_o  (tmr_expired)
    );

    // Scan FSM: IDLE -> BLANK -> SHOW -> BLANK(sel+1) ...; en low forces IDLE.
    // Nothing moves until arm_q is set, one clock after reset release.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        fd_d         = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (arm_q) begin
            if (!en) begin
                state_d  = ST_IDLE;
                sel_d    = '0;
                tmr_load = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d      = ST_BLANK;
                        sel_d        = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = BLANK_LOAD;
                    end
                    ST_BLANK: begin
                        if (tmr_expired) begin
                            state_d      = ST_SHOW;
                            tmr_load     = 1'b1;
                            tmr_load_val = SHOW_LOAD;
                        end
                    end
                    ST_SHOW: begin
                        if (tmr_expired) begin
                            state_d      = ST_BLANK;
                            sel_d        = sel_q + 1'b1;
                            fd_d         = (sel_q == LAST_SEL);
                            tmr_load     = 1'b1;
                            tmr_load_val = BLANK_LOAD;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        sel_d    = '0;
                        tmr_load = 1'b1;
                    end
                endcase
            end
        end
    end

    // Frame buffers: accept into pending, commit at frame boundary or while disabled.
    // Accept and commit are mutually exclusive since accept needs pending empty.
    always_comb begin
        accept     = wr_valid && wr_ready_q;
        commit     = !wr_ready_q && (fd_d || !en);
        pend_d     = accept ? wr_data : pend_q;
        shadow_d   = commit ? pend_q : shadow_q;
        wr_ready_d = wr_ready_q;
        if (commit) begin
            wr_ready_d = 1'b1;
        end
        if (accept) begin
            wr_ready_d = 1'b0;
        end
        blank_d = (state_d != ST_SHOW);
        data_d  = digit_of(shadow_d, sel_d);
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q      <= 1'b0;
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            data_q     <= '0;
            blank_q    <= 1'b1;
            fd_q       <= 1'b0;
            wr_ready_q <= 1'b1;
            shadow_q   <= '0;
            pend_q     <= '0;
        end else begin
            arm_q      <= 1'b1;
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            blank_q    <= blank_d;
            fd_q       <= fd_d;
            wr_ready_q <= wr_ready_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign sel        = sel_q;
    assign data       = data_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Directed bench for ss_scan_ctrl with SHOW_CYCLES=4, BLANK_CYCLES=2
// (6 clocks per digit, 24 clocks per frame).
module tb_ss_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        wr_valid;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic [1:0]  sel;
    logic [2:0]  data;
    logic        blank;
    logic        frame_done;

    int n_tests;
    int n_fail;
    int wait_n;

    ss_scan_ctrl #(
        .SHOW_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .sel        (sel),
        .data       (data),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] dig(input logic [11:0] f, input logic [1:0] i);
        return f[i*3 +: 3];
    endfunction

    // Step until frame_done, checking the displayed (old) frame every cycle.
    task automatic wait_fd(input int budget, input logic [11:0] old_frame, output int n);
        n = 0;
        step(1);
        n++;
        while (!frame_done && n < budget) begin
            check("hold_data", int'(data), int'(dig(old_frame, sel)));
            step(1);
            n++;
        end
        check("fd_seen", int'(frame_done), 1);
    endtask

    task automatic write(input logic [11:0] v);
        wr_valid = 1'b1;
        wr_data  = v;
        step(1);
        wr_valid = 1'b0;
        wr_data  = 12'h000;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 12'h000;

        // Reset values
        step(2);
        check("rst_sel", int'(sel), 0);
        check("rst_data", int'(data), 0);
        check("rst_blank", int'(blank), 1);
        check("rst_fd", int'(frame_done), 0);
        check("rst_ready", int'(wr_ready), 1);
        $display("[TB] reset values checked");

        // Steady scan: release between edges, first state change on 2nd edge
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        for (int k = 0; k <= 48; k++) begin
            check("scan_sel", int'(sel), (k / 6) % 4);
            check("scan_blank", int'(blank), ((k % 6) < 2) ? 1 : 0);
            check("scan_fd", int'(frame_done), (k > 0 && (k % 24) == 0) ? 1 : 0);
            check("scan_data", int'(data), 0);
            if (k < 48) step(1);
        end
        $display("[TB] steady scan of two frames checked");

        // Mid-frame write of 0x0FA commits at next frame_done
        step(8);
        write(12'h0FA);
        check("wr_ready_drop", int'(wr_ready), 0);
        wait_fd(30, 12'h000, wait_n);
        check("c1_sel0", int'(sel), 0);
        check("c1_data0", int'(data), 2);
        check("c1_ready", int'(wr_ready), 1);
        step(6);
        check("c1_sel1", int'(sel), 1);
        check("c1_data1", int'(data), 7);
        $display("[TB] write 0x0FA committed");

        // Two writes in one frame: the second is ignored
        write(12'h123);
        check("c2_ready", int'(wr_ready), 0);
        write(12'h555);
        wait_fd(30, 12'h0FA, wait_n);
        check("c2_data0", int'(data), 3);
        check("c2_ready_back", int'(wr_ready), 1);
        step(6);
        check("c2_data1", int'(data), 4);
        $display("[TB] second write ignored");

        // Write accepted on the boundary edge commits one frame later
        step(17);
        check("c3_pre_sel", int'(sel), 3);
        check("c3_pre_blank", int'(blank), 0);
        check("c3_pre_fd", int'(frame_done), 0);
        write(12'h009);
        check("c3_fd", int'(frame_done), 1);
        check("c3_ready", int'(wr_ready), 0);
        check("c3_old_data", int'(data), 3);
        wait_fd(30, 12'h123, wait_n);
        check("c3_delay", wait_n, 24);
        check("c3_new_data", int'(data), 1);
        check("c3_ready_back", int'(wr_ready), 1);
        $display("[TB] boundary write committed a frame later");

        // en dropped during SHOW of sel=2, write while disabled commits at once
        step(14);
        check("e_pre_sel", int'(sel), 2);
        check("e_pre_blank", int'(blank), 0);
        en = 1'b0;
        step(1);
        check("e_off_blank", int'(blank), 1);
        check("e_off_sel", int'(sel), 0);
        check("e_off_fd", int'(frame_done), 0);
        check("e_off_data", int'(data), 1);
        step(3);
        check("e_idle_blank", int'(blank), 1);
        check("e_idle_fd", int'(frame_done), 0);
        write(12'h00E);
        check("e_wr_ready", int'(wr_ready), 0);
        check("e_wr_data_old", int'(data), 1);
        step(1);
        check("e_commit_ready", int'(wr_ready), 1);
        check("e_commit_data", int'(data), 6);
        en = 1'b1;
        step(1);
        check("e_on_blank", int'(blank), 1);
        check("e_on_sel", int'(sel), 0);
        check("e_on_fd", int'(frame_done), 0);
        step(1);
        check("e_on_blank2", int'(blank), 1);
        step(1);
        check("e_show_blank", int'(blank), 0);
        check("e_show_sel", int'(sel), 0);
        check("e_show_data", int'(data), 6);
        $display("[TB] disable and restart checked");

        // Reset pulse mid-SHOW with pending full
        step(5);
        write(12'h0FF);
        check("r_pre_ready", int'(wr_ready), 0);
        check("r_pre_sel", int'(sel), 1);
        check("r_pre_blank", int'(blank), 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("r_sel", int'(sel), 0);
        check("r_data", int'(data), 0);
        check("r_blank", int'(blank), 1);
        check("r_fd", int'(frame_done), 0);
        check("r_ready", int'(wr_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        check("r2_blank", int'(blank), 1);
        check("r2_data", int'(data), 0);
        wait_fd(30, 12'h000, wait_n);
        check("r2_period", wait_n, 24);
        check("r2_sel", int'(sel), 0);
        check("r2_data_after", int'(data), 0);
        $display("[TB] reset mid-frame checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ss_scan_ctrl.md
SS_SCAN_CTRL -- requirements
Module: ss_scan_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 1000: clocks each digit is driven (minimum 1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: dead-time clocks before each digit, with all anodes off (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  scan enable; 0 blanks the display.
REQ-006 SHALL have port wr_valid  input  1  new frame offered.
REQ-007 SHALL have port wr_data  input  12  four 3-bit digits: [2:0]=digit0 … [11:9]=digit3.
REQ-008 SHALL have port wr_ready  output  1  pending buffer empty; write accepted when wr_valid&&wr_ready.
REQ-009 SHALL have port sel  output  2  digit index to the segment driver.
REQ-010 SHALL have port data  output  3  shadow digit selected by sel.
REQ-011 SHALL have port blank  output  1  1 forces all anodes off.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of digit-3 SHOW.

Function
REQ-013 SHALL implement states IDLE, BLANK, SHOW.
- Encoding is left to the implementation.
- All outputs SHALL be registered.
REQ-014 IDLE: blank=1, sel=0, counter cleared.
- en=1 moves to BLANK with sel=0 on the next edge.
REQ-015 BLANK: blank=1 for exactly BLANK_CYCLES clocks, then SHOW with sel unchanged.
REQ-016 SHOW: blank=0 for exactly SHOW_CYCLES clocks, then BLANK with sel=sel+1 (mod 4; 3 wraps to 0).
REQ-017 data SHALL equal shadow[sel] in every cycle, including BLANK and IDLE.
REQ-018 frame_done SHALL pulse in the cycle after the last SHOW clock of sel=3, together with the first BLANK cycle of sel=0.
REQ-019 An accepted write SHALL store wr_data in the pending buffer; wr_ready SHALL drop on the next edge.
REQ-020 At a frame boundary (REQ-018 edge), a full pending buffer SHALL copy into shadow and wr_ready SHALL return to 1 on the same edge.
- Shadow SHALL never change mid-frame.
REQ-021 A write accepted on the boundary edge itself SHALL go to pending and commit only at the next boundary.
REQ-022 A write attempted while wr_ready=0 SHALL be ignored; wr_data is don't-care.
REQ-023 en deasserting in any state SHALL enter IDLE on the next edge (blank=1, sel=0).
- No frame_done pulse.
- Pending and shadow contents are retained.
REQ-024 While en=0, if pending is full, it SHALL commit to shadow immediately (next edge) so the next enable shows the latest frame.
REQ-025 The cycle counter SHALL be $clog2(max(SHOW_CYCLES,BLANK_CYCLES)+1) bits wide.
- It SHALL never wrap within a phase.

Reset
REQ-026 rst_n=0 SHALL asynchronously force:
- state=IDLE, sel=0, data=0, blank=1, frame_done=0, wr_ready=1, counter=0, shadow=0, pending empty.
REQ-027 Reset assertion mid-frame SHALL discard pending data.
- Release SHALL be synchronous-safe: first state change on the second edge after rst_n rises.

Structure
REQ-028 Package ss_pkg SHALL hold:
- the state typedef,
- DIGITS=4, DIGIT_W=3,
- the frame width (DIGITS*DIGIT_W).
REQ-029 Sub-module ss_phase_timer SHALL hold the loadable down-counter and signal phase expiry; the FSM and buffers stay in ss_scan_ctrl.

Verification (SHOW_CYCLES=4, BLANK_CYCLES=2)
REQ-030 Reset, en=1, steady → sel sequence 0,1,2,3,0; blank pattern 1,1,0,0,0,0 repeating; frame_done period 24 clocks.
REQ-031 Write 12'h0FA mid-frame → data unchanged until frame_done; afterwards sel=0 gives data=2 and sel=1 gives data=7; wr_ready back to 1 at frame_done.
REQ-032 Two writes in one frame: second offered while wr_ready=0 → ignored; first value is displayed.
REQ-033 Write accepted on the frame_done edge → committed one frame (24 clocks) later, not immediately.
REQ-034 en dropped during SHOW of sel=2 → next cycle blank=1, sel=0, no frame_done; en=1 again → restarts at BLANK sel=0.
REQ-035 rst_n pulsed low mid-SHOW with pending full → outputs at reset values immediately; wr_ready=1; shadow=0.
